// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through cache controller.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_t;

    // Widest tag the line struct can carry; narrower tags are zero-extended into it.
    localparam int TAG_MAX_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          data;
    } line_t;

    function automatic int index_width(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_width(input int lines, input int mem_size);
        return $clog2(mem_size) - $clog2(lines);
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for the cache: combinational lookup, one synchronous write port,
// and synchronous invalidation of every line on reset.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int LINES    = 16,
    parameter int MEM_SIZE = 4096,
    localparam int IW      = index_width(LINES),
    localparam int TW      = tag_width(LINES, MEM_SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] lookup_index,
    input  logic [TW-1:0] lookup_tag,
    output logic          lookup_hit,
    output logic [31:0]   lookup_data,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_index,
    input  logic [TW-1:0] wr_tag,
    input  logic [31:0]   wr_data
);

    logic [LINES-1:0] valid_reg;
    logic [TW-1:0]    tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];
    line_t            rd_line;

    // Any write leaves the line valid: fills set it, write hits find it already set.
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg[gi] <= 1'b0;
                end else if (wr_en && (wr_index == IW'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    always_comb begin
        rd_line       = '0;
        rd_line.valid = valid_reg[lookup_index];
        rd_line.tag   = TAG_MAX_W'(tag_mem[lookup_index]);
        rd_line.data  = data_mem[lookup_index];
    end

    assign lookup_hit  = rd_line.valid && (rd_line.tag == TAG_MAX_W'(lookup_tag));
    assign lookup_data = rd_line.data;

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller in front of a word-addressed ram.
// Optional CACHE_STATS_EN adds 32-bit read hit/miss counters as outputs.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int LINES    = 16,
    parameter int MEM_SIZE = 4096,
    parameter int TIMEOUT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_data,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic        cpu_ready,
    output logic [31:0] cpu_out,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_write,
    input  logic        mem_response,
    input  logic [31:0] mem_out
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IW = index_width(LINES);
    localparam int TW = tag_width(LINES, MEM_SIZE);
    localparam int AW = IW + TW;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   cpu_out_reg, cpu_out_next;
    logic [31:0]   mem_address_reg, mem_address_next;
    logic [31:0]   mem_data_reg, mem_data_next;
    logic          mem_write_reg, mem_write_next;

    logic [AW-1:0] cpu_a;
    logic [IW-1:0] cpu_index;
    logic [TW-1:0] cpu_tag;
    logic [AW-1:0] txn_a;
    logic          lookup_hit;
    logic [31:0]   lookup_data;
    logic          wr_en;
    logic [IW-1:0] wr_index;
    logic [TW-1:0] wr_tag;
    logic [31:0]   wr_data;
    logic          complete;
    logic          unused_addr_bits;

    assign cpu_a     = cpu_address[AW-1:0];
    assign cpu_index = cpu_a[IW-1:0];
    assign cpu_tag   = cpu_a[AW-1:IW];
    assign unused_addr_bits = &{1'b0, cpu_address[31:AW]};

    // The launched request stays in the mem registers, so they also name the line to fill.
    assign txn_a = mem_address_reg[AW-1:0];

    cache_line_array #(
        .LINES   (LINES),
        .MEM_SIZE(MEM_SIZE)
    ) u_lines (
        .clk         (clk),
        .reset       (reset),
        .lookup_index(cpu_index),
        .lookup_tag  (cpu_tag),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .wr_en       (wr_en),
        .wr_index    (wr_index),
        .wr_tag      (wr_tag),
        .wr_data     (wr_data)
    );

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        cpu_out_next     = cpu_out_reg;
        mem_address_next = mem_address_reg;
        mem_data_next    = mem_data_reg;
        mem_write_next   = mem_write_reg;
        wr_en            = 1'b0;
        wr_index         = cpu_index;
        wr_tag           = cpu_tag;
        wr_data          = cpu_data;
        complete         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cpu_write) begin
                    wr_en            = lookup_hit;
                    mem_address_next = 32'(cpu_a);
                    mem_data_next    = cpu_data;
                    mem_write_next   = 1'b1;
                    cnt_next         = '0;
                    state_next       = WAIT_HI;
                end else if (cpu_read) begin
                    if (lookup_hit) begin
                        cpu_out_next = lookup_data;
                        state_next   = DONE;
                    end else begin
                        mem_address_next = 32'(cpu_a);
                        mem_write_next   = 1'b0;
                        cnt_next         = '0;
                        state_next       = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                if (mem_response) begin
                    cnt_next   = '0;
                    state_next = WAIT_LO;
                end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                    // No edge from ram: the request repeated the previous one, mem_out is current.
                    cnt_next = '0;
                    complete = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            WAIT_LO: begin
                if (!mem_response) begin
                    complete = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (complete) begin
            state_next = DONE;
            if (!mem_write_reg) begin
                wr_en        = 1'b1;
                wr_index     = txn_a[IW-1:0];
                wr_tag       = txn_a[AW-1:IW];
                wr_data      = mem_out;
                cpu_out_next = mem_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            cpu_out_reg     <= '0;
            mem_address_reg <= '0;
            mem_data_reg    <= '0;
            mem_write_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            cpu_out_reg     <= cpu_out_next;
            mem_address_reg <= mem_address_next;
            mem_data_reg    <= mem_data_next;
            mem_write_reg   <= mem_write_next;
        end
    end

    assign cpu_ready   = (state_reg == DONE);
    assign cpu_out     = cpu_out_reg;
    assign mem_address = mem_address_reg;
    assign mem_data    = mem_data_reg;
    assign mem_write   = mem_write_reg;

`ifdef CACHE_STATS_EN
    logic        hit_inc;
    logic        miss_inc;
    logic [31:0] hit_count_reg;
    logic [31:0] miss_count_reg;

    assign hit_inc  = (state_reg == IDLE) && !cpu_write && cpu_read && lookup_hit;
    assign miss_inc = (state_reg == IDLE) && !cpu_write && cpu_read && !lookup_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (hit_inc) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
            if (miss_inc) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: directed scenarios plus random traffic against a
// behavioural cache/ram model; a monitor checks every cpu_ready pulse.
module tb_cache_ctrl;

    localparam int LINES    = 16;
    localparam int MEM_SIZE = 4096;
    localparam int TIMEOUT  = 4;
    localparam int MAW      = $clog2(MEM_SIZE);
    localparam int LAT_MEM  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cpu_address = '0;
    logic [31:0] cpu_data = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic        cpu_ready;
    logic [31:0] cpu_out;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_write;
    logic        mem_response = 1'b0;
    logic [31:0] mem_out = '0;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    cache_ctrl #(
        .LINES   (LINES),
        .MEM_SIZE(MEM_SIZE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_address (cpu_address),
        .cpu_data    (cpu_data),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_ready   (cpu_ready),
        .cpu_out     (cpu_out),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_write   (mem_write),
        .mem_response(mem_response),
        .mem_out     (mem_out)
`ifdef CACHE_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 32'h10) return 32'hDEADBEEF;
        return (i * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Behavioural ram: any change of the request performs one access and pulses response.
    logic [31:0] ram [MEM_SIZE];
    logic        ram_loaded = 1'b0;
    logic [31:0] ram_prev_addr = 32'hFFFFFFFF;
    logic [31:0] ram_prev_data = 32'hFFFFFFFF;
    logic        ram_prev_write = 1'b1;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < MEM_SIZE; i++) ram[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else if (mem_address != ram_prev_addr || mem_data != ram_prev_data ||
                     mem_write != ram_prev_write) begin
            ram_prev_addr  <= mem_address;
            ram_prev_data  <= mem_data;
            ram_prev_write <= mem_write;
            if (mem_write) begin
                ram[mem_address[MAW-1:0]] <= mem_data;
                mem_out <= mem_data;
            end else begin
                mem_out <= ram[mem_address[MAW-1:0]];
            end
            mem_response <= 1'b1;
        end else begin
            mem_response <= 1'b0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    typedef struct {
        string       name;
        logic        is_read;
        logic [31:0] addr;
        logic [31:0] data;
        int          k;
        int          lat;
        logic [31:0] maddr;
        logic        mwrite;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: cache contents, memory image and the request ram last saw.
    logic        m_valid [LINES];
    int unsigned m_tag   [LINES];
    logic [31:0] m_data  [LINES];
    logic [31:0] model_mem [MEM_SIZE];
    logic [31:0] last_addr;
    logic [31:0] last_data;
    logic        last_write;
    int          m_hits;
    int          m_misses;

    always @(negedge clk) begin
        if (cpu_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_ready", {31'b0, cpu_ready}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_latency"}, 32'(cyc - e.k), 32'(e.lat));
                if (e.is_read) check({e.name, "_data"}, cpu_out, e.data);
                check({e.name, "_mem_address"}, mem_address, e.maddr);
                check({e.name, "_mem_write"}, {31'b0, mem_write}, {31'b0, e.mwrite});
                $display("txn %s %s addr=%h data=%h lat=%0d", e.name,
                         e.is_read ? "rd" : "wr", e.addr, e.is_read ? cpu_out : e.data,
                         cyc - e.k);
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        last_addr  = '0;
        last_data  = '0;
        last_write = 1'b0;
        m_hits     = 0;
        m_misses   = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
    endtask

    // Called at a negedge; the request is sampled at the following posedge.
    task automatic do_req(input string name, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input bit abort);
        exp_t        e;
        logic [31:0] a;
        int          idx;
        int unsigned tg;
        bit          seen;
        a   = addr & (MEM_SIZE - 1);
        idx = int'(a % LINES);
        tg  = a / LINES;
        e.name = name;
        e.addr = addr;
        e.k    = cyc + 1;
        e.is_read = !wr;
        e.data = data;
        if (wr) begin
            if (m_valid[idx] && m_tag[idx] == tg) m_data[idx] = data;
            model_mem[a] = data;
            e.lat = (last_write && last_addr == a && last_data == data) ? TIMEOUT : LAT_MEM;
            last_addr = a; last_data = data; last_write = 1'b1;
        end else if (m_valid[idx] && m_tag[idx] == tg) begin
            e.lat  = 0;
            e.data = m_data[idx];
            m_hits++;
        end else begin
            e.lat  = (!last_write && last_addr == a) ? TIMEOUT : LAT_MEM;
            e.data = model_mem[a];
            m_valid[idx] = 1'b1; m_tag[idx] = tg; m_data[idx] = model_mem[a];
            last_addr = a; last_write = 1'b0;
            m_misses++;
        end
        e.maddr  = last_addr;
        e.mwrite = last_write;
        cpu_address = addr;
        cpu_data    = wr ? data : $urandom;
        cpu_write   = wr;
        cpu_read    = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        if (abort && !wr && e.lat == LAT_MEM) begin
            repeat (3) @(negedge clk);
            check({name, "_abort_not_ready"}, {31'b0, cpu_ready}, 32'd0);
            do_reset();
            return;
        end
        exp_q.push_back(e);
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (cpu_ready) seen = 1'b1;
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        if (!seen) begin
            check({name, "_ready_timeout"}, 32'd0, 32'd1);
            do_reset();
        end else begin
            @(negedge clk);
        end
    endtask

    initial begin
        int bad;
        for (int i = 0; i < MEM_SIZE; i++) model_mem[i] = init_word(i);
        model_reset();
        do_reset();
        check("reset_cpu_ready", {31'b0, cpu_ready}, 32'd0);
        check("reset_cpu_out", cpu_out, 32'd0);
        check("reset_mem_address", mem_address, 32'd0);
        check("reset_mem_data", mem_data, 32'd0);
        check("reset_mem_write", {31'b0, mem_write}, 32'd0);

        do_req("miss_10", 1'b0, 32'h10, 32'h0, 1'b0);
        do_req("miss_05", 1'b0, 32'h05, 32'h0, 1'b0);
        do_req("hit_10", 1'b0, 32'h10, 32'h0, 1'b0);
        do_req("write_10", 1'b1, 32'h10, 32'h12345678, 1'b0);
        do_req("hit_10_new", 1'b0, 32'h10, 32'h0, 1'b0);
        do_req("miss_20", 1'b0, 32'h20, 32'h0, 1'b0);
        do_req("remiss_10", 1'b0, 32'h10, 32'h0, 1'b0);
        do_req("alias_hi_bits", 1'b0, 32'hABCD5010, 32'h0, 1'b0);
        do_reset();
        do_req("timeout_rd_0", 1'b0, 32'h0, 32'h0, 1'b0);
        do_req("hit_0", 1'b0, 32'h0, 32'h0, 1'b0);
        do_req("write_30", 1'b1, 32'h30, 32'h7, 1'b0);
        do_req("timeout_wr_30", 1'b1, 32'h30, 32'h7, 1'b0);
        do_req("abort_10", 1'b0, 32'h10, 32'h0, 1'b1);
        do_req("after_abort_10", 1'b0, 32'h10, 32'h0, 1'b0);

        for (int t = 0; t < 300; t++) begin
            logic [31:0] addr;
            logic [31:0] data;
            logic        wr;
            addr = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 15)) << MAW);
            data = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
            wr   = ($urandom_range(0, 3) == 0);
            do_req("rand", wr, addr, data, $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) do_reset();
        end

`ifdef CACHE_STATS_EN
        check("hit_count", hit_count, 32'(m_hits));
        check("miss_count", miss_count, 32'(m_misses));
`endif
        bad = 0;
        for (int i = 0; i < MEM_SIZE; i++) if (ram[i] !== model_mem[i]) bad++;
        check("ram_contents", 32'(bad), 32'd0);
        check("ram_10", ram[32'h10], model_mem[32'h10]);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
